// File: rtl/mem_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_writeback_pkg
// Description : Shared access-size and FSM state encodings for the MEM/WB stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_writeback_pkg;

    localparam logic [1:0] SZ_NONE   = 2'b00;
    localparam logic [1:0] WORD      = 2'b01;
    localparam logic [1:0] HALFWORD  = 2'b10;
    localparam logic [1:0] BYTE      = 2'b11;

    localparam logic [0:0] MW_IDLE   = 1'b0;
    localparam logic [0:0] MW_ACCESS = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_writeback_load_aligner.sv
`default_nettype none
// ============================================================================
// Module      : load_aligner
// Description : Selects the addressed big-endian lane and sign-extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_aligner
    import mem_writeback_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  size_in,
    input  logic [1:0]  offset_in,
    output logic [31:0] data_out
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = 8'h00;
        w_half   = 16'h0000;
        data_out = rdata_in;
        case (offset_in)
            2'd0:    w_byte = rdata_in[31:24];
            2'd1:    w_byte = rdata_in[23:16];
            2'd2:    w_byte = rdata_in[15:8];
            default: w_byte = rdata_in[7:0];
        endcase
        w_half = offset_in[1] ? rdata_in[15:0] : rdata_in[31:16];
        case (size_in)
            BYTE:     data_out = {{24{w_byte[7]}}, w_byte};
            HALFWORD: data_out = {{16{w_half[15]}}, w_half};
            default:  data_out = rdata_in;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_writeback.sv
`default_nettype none
// ============================================================================
// Module      : mem_writeback
// Description : MEM/WB pipeline stage: req/ack data-memory access and
//               registered register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              EXMEM_valid_in,
    input  logic [31:0]       EXMEM_alu_result_in,
    input  logic [31:0]       EXMEM_b_in,
    input  logic [4:0]        EXMEM_reg_write_address_in,
    input  logic [1:0]        EXMEM_ctrl_mem_read_in,
    input  logic [1:0]        EXMEM_ctrl_mem_write_in,
    input  logic              EXMEM_ctrl_reg_write_in,
    input  logic              EXMEM_ctrl_mem_to_reg_in,
    output logic              stall_out,
    output logic              dmem_req_out,
    output logic              dmem_we_out,
    output logic [ADDR_W-1:0] dmem_addr_out,
    output logic [31:0]       dmem_wdata_out,
    output logic [3:0]        dmem_be_out,
    input  logic              dmem_ack_in,
    input  logic [31:0]       dmem_rdata_in,
    output logic [4:0]        WB_reg_write_address_out,
    output logic [31:0]       WB_reg_write_data_out,
    output logic              WB_ctrl_reg_write_out,
    output logic              misalign_out
);

    logic [0:0]  r_state, w_state_next;
    logic [1:0]  r_size, r_offset;
    logic [4:0]  r_dest;
    logic        r_reg_write, r_mem_to_reg;
    logic [31:0] r_alu;

    logic        w_is_write, w_mem_op, w_misaligned, w_start;
    logic [1:0]  w_size, w_offset;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;

    // A nonzero store size wins over a simultaneous load size.
    assign w_is_write = (EXMEM_ctrl_mem_write_in != SZ_NONE);
    assign w_size     = w_is_write ? EXMEM_ctrl_mem_write_in : EXMEM_ctrl_mem_read_in;
    assign w_mem_op   = EXMEM_valid_in && (w_size != SZ_NONE);
    assign w_offset   = EXMEM_alu_result_in[1:0];
    assign w_misaligned = ((w_size == WORD) && (w_offset != 2'b00)) ||
                          ((w_size == HALFWORD) && w_offset[0]);
    assign w_start    = (r_state == MW_IDLE) && w_mem_op && !w_misaligned;

    assign stall_out  = w_start || ((r_state == MW_ACCESS) && !dmem_ack_in);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = EXMEM_b_in;
        case (w_size)
            BYTE: begin
                w_be    = 4'b1000 >> w_offset;
                w_wdata = {4{EXMEM_b_in[7:0]}};
            end
            HALFWORD: begin
                w_be    = w_offset[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{EXMEM_b_in[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MW_IDLE:   if (w_start) w_state_next = MW_ACCESS;
            default:   if (dmem_ack_in) w_state_next = MW_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= MW_IDLE;
        else        r_state <= w_state_next;
    end

    load_aligner u_load_aligner (
        .rdata_in  (dmem_rdata_in),
        .size_in   (r_size),
        .offset_in (r_offset),
        .data_out  (w_load_data)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dmem_req_out             <= 1'b0;
            dmem_we_out              <= 1'b0;
            dmem_addr_out            <= '0;
            dmem_wdata_out           <= 32'h0;
            dmem_be_out              <= 4'h0;
            WB_reg_write_address_out <= 5'd0;
            WB_reg_write_data_out    <= 32'h0;
            WB_ctrl_reg_write_out    <= 1'b0;
            misalign_out             <= 1'b0;
            r_size                   <= SZ_NONE;
            r_offset                 <= 2'b00;
            r_dest                   <= 5'd0;
            r_reg_write              <= 1'b0;
            r_mem_to_reg             <= 1'b0;
            r_alu                    <= 32'h0;
        end else if (r_state == MW_IDLE) begin
            misalign_out <= w_mem_op && w_misaligned;
            if (w_start) begin
                dmem_req_out          <= 1'b1;
                dmem_we_out           <= w_is_write;
                dmem_addr_out         <= {EXMEM_alu_result_in[ADDR_W-1:2], 2'b00};
                dmem_wdata_out        <= w_wdata;
                dmem_be_out           <= w_be;
                r_size                <= w_size;
                r_offset              <= w_offset;
                r_dest                <= EXMEM_reg_write_address_in;
                r_reg_write           <= EXMEM_ctrl_reg_write_in;
                r_mem_to_reg          <= EXMEM_ctrl_mem_to_reg_in;
                r_alu                 <= EXMEM_alu_result_in;
                WB_ctrl_reg_write_out <= 1'b0;
            end else begin
                WB_reg_write_address_out <= EXMEM_reg_write_address_in;
                WB_reg_write_data_out    <= EXMEM_alu_result_in;
                WB_ctrl_reg_write_out    <= EXMEM_valid_in && !w_mem_op &&
                                            EXMEM_ctrl_reg_write_in &&
                                            (EXMEM_reg_write_address_in != 5'd0);
            end
        end else begin
            misalign_out <= 1'b0;
            if (dmem_ack_in) begin
                dmem_req_out             <= 1'b0;
                WB_reg_write_address_out <= r_dest;
                WB_reg_write_data_out    <= r_mem_to_reg ? w_load_data : r_alu;
                WB_ctrl_reg_write_out    <= !dmem_we_out && r_reg_write && (r_dest != 5'd0);
            end else begin
                WB_ctrl_reg_write_out    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
